fifo_wr_rr_arbiter: RTL
=======================

// Module: fifo_wr_rr_arbiter
// PURPOSE
//  Round-robin burst arbiter sharing the write port of one prefetch FIFO (wr_en/wr_vld/wr_data) among N_SRC sources.
//  Sits in front of the FIFO write side in the same clock domain as wr_clk.
//  Each source offers a valid/ready stream with a last marker; grant is held for one burst, then rotates.
// PARAMETERS
//  N_SRC      4    number of requesting sources (2..8)
//  DATA_W     32   beat width, equals FIFO write data width
//  BURST_MAX  16   max beats per grant (1..256); grant released on reaching it
//  STALL_MAX  8    consecutive granted-source idle cycles (src_valid=0) before forced release (1..255)
//  SRC_W      $clog2(N_SRC)  localparam, grant index width
// PORTS
//  clk           in   1               single clock (FIFO wr_clk)
//  rst_n         in   1               asynchronous, active-low reset
//  src_valid     in   N_SRC           per-source beat valid
//  src_data      in   N_SRC*DATA_W    per-source beat data, source i at [i*DATA_W +: DATA_W]
//  src_last      in   N_SRC           per-source last beat of packet, qualified by src_valid
//  src_ready     out  N_SRC           per-source accept; beat moves when src_valid[i]&src_ready[i]
//  fifo_wr_en    out  1               FIFO write enable
//  fifo_wr_data  out  DATA_W          FIFO write data
//  fifo_wr_vld   in   1               FIFO can accept this cycle (not full)
//  grant_idx     out  SRC_W           currently granted source (valid when busy=1)
//  busy          out  1               1 in BURST state
//  burst_done    out  1               1-cycle pulse on the cycle a burst ends
// BEHAVIOUR
//  Reset (rst_n=0, immediate): state=IDLE, rr_ptr=0, grant_idx=0, beat_cnt=0, stall_cnt=0; all outputs 0.
//  States: IDLE, BURST.
//  IDLE: src_ready=0, fifo_wr_en=0. If any src_valid: grant = first i with src_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N_SRC.
//   Grant is registered; go to BURST next cycle (1-cycle arbitration latency). Else stay.
//  BURST (g=grant_idx), combinational datapath, 0-cycle latency:
//   fifo_wr_en=src_valid[g]; fifo_wr_data=src_data[g]; src_ready[g]=fifo_wr_vld, other src_ready=0.
//   beat = src_valid[g] & fifo_wr_vld; beat_cnt += beat.
//   stall_cnt: +1 when src_valid[g]=0, cleared when src_valid[g]=1. FIFO backpressure is not a stall.
//   End condition (any):
//    (a) beat & src_last[g];
//    (b) beat & beat_cnt+1==BURST_MAX;
//    (c) src_valid[g]=0 & stall_cnt+1==STALL_MAX.
//   On end: burst_done=1 same cycle; next state IDLE; rr_ptr=(g+1) mod N_SRC; beat_cnt,stall_cnt cleared.
//   Coincident (a)&(b): a single end, a single pulse.
//  Each burst costs exactly 1 idle cycle (IDLE) between grants. Max throughput is BURST_MAX/(BURST_MAX+1).
//  fifo_wr_vld=0 during BURST: fifo_wr_en follows src_valid, no beat, and nothing is counted.
//   The FIFO qualifies the write with wr_vld; the arbiter holds the grant indefinitely.
//  src_last/src_valid of non-granted sources are ignored. src_last in IDLE is ignored.
//  A packet longer than BURST_MAX is split across grants. The source resumes on its next grant.
//  Widths:
//   beat_cnt is $clog2(BURST_MAX+1) bits and never wraps (cleared at BURST_MAX).
//   stall_cnt is 8 bits and saturates at end.
//  Reset mid-burst: outputs drop immediately. Beats already written stay in the FIFO (no rollback).
//   After release, arbitration restarts from source 0.
// TESTING
//  1. Only src 2 valid, 5-beat packet (last on beat 5), fifo_wr_vld=1: grant at cycle 1.
//     5 writes cycles 2-6, burst_done cycle 6, busy=0 cycle 7.
//  2. All 4 sources continuously valid, no last, BURST_MAX=16: grants 0,1,2,3,0.
//     Each grant 16 writes then burst_done. Exactly 1 bubble between grants.
//  3. Grant on src 1, fifo_wr_vld=0 for 20 cycles mid-burst: no stall release, beat_cnt frozen.
//     Burst resumes and completes the remaining beats.
//  4. Grant on src 0, src_valid[0] drops after 3 beats, STALL_MAX=8: burst_done on 8th idle cycle.
//     Next grant goes to src 1 if valid.
//  5. src_last on beat 16 with BURST_MAX=16: one burst_done pulse, rr_ptr advances by 1 only.
//  6. Assert rst_n=0 mid-burst at beat 7: fifo_wr_en/src_ready/busy low immediately.
//     After release, src 0 is granted first when all sources are valid.

Source files
------------

// File: rtl/fifo_wr_rr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_SRC valid/ready sources.
// One arbitration cycle per grant; the granted source streams straight into the FIFO.
module fifo_wr_rr_arbiter #(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 16,
  parameter int STALL_MAX = 8,
  localparam int SRC_W    = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic [N_SRC-1:0]        src_last,
  output logic [N_SRC-1:0]        src_ready,
  output logic                    fifo_wr_en,
  output logic [DATA_W-1:0]       fifo_wr_data,
  input  logic                    fifo_wr_vld,
  output logic [SRC_W-1:0]        grant_idx,
  output logic                    busy,
  output logic                    burst_done
);

  localparam int BCNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]  grant_q, grant_d;
  logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [7:0]        stall_cnt_q, stall_cnt_d;

  logic [DATA_W-1:0] src_words [N_SRC];
  logic [SRC_W-1:0]  rr_pick;
  logic              pick_vld;
  logic              g_valid, g_last, beat, end_burst;
  logic [31:0]       idx;

  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      src_words[i] = src_data[i*DATA_W +: DATA_W];
    end
  end

  // First requester found scanning upward from rr_ptr, wrapping at N_SRC.
  always_comb begin
    pick_vld = 1'b0;
    rr_pick  = rr_ptr_q;
    idx      = '0;
    for (int unsigned off = 0; off < N_SRC; off++) begin
      idx = (32'(rr_ptr_q) + off) % N_SRC;
      if (!pick_vld && src_valid[idx]) begin
        pick_vld = 1'b1;
        rr_pick  = SRC_W'(idx);
      end
    end
  end

  assign g_valid   = src_valid[grant_q];
  assign g_last    = src_last[grant_q];
  assign grant_idx = grant_q;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    beat_cnt_d   = beat_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    src_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    busy         = 1'b0;
    burst_done   = 1'b0;
    beat         = 1'b0;
    end_burst    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = rr_pick;
          state_d = BURST;
        end
      end
      BURST: begin
        busy               = 1'b1;
        fifo_wr_en         = g_valid;
        fifo_wr_data       = src_words[grant_q];
        src_ready[grant_q] = fifo_wr_vld;
        beat               = g_valid & fifo_wr_vld;

        if (beat) begin
          beat_cnt_d = beat_cnt_q + BCNT_W'(1);
        end
        // FIFO backpressure leaves the stall counter untouched only via g_valid.
        if (g_valid) begin
          stall_cnt_d = '0;
        end else if (stall_cnt_q != '1) begin
          stall_cnt_d = stall_cnt_q + 8'd1;
        end

        end_burst = (beat && (g_last || (32'(beat_cnt_q) + 32'd1 == BURST_MAX)))
                 || (!g_valid && (32'(stall_cnt_q) + 32'd1 == STALL_MAX));

        if (end_burst) begin
          burst_done  = 1'b1;
          state_d     = IDLE;
          rr_ptr_d    = (grant_q == SRC_W'(N_SRC - 1)) ? '0 : grant_q + SRC_W'(1);
          beat_cnt_d  = '0;
          stall_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
